cfo_correction: RTL and testbench
=================================

Name: cfo_correction

Overview:
- Frequency-correction stage directly downstream of the CFO estimator; consumes its DDS phase increment.
- Derotates the baseband IQ stream with a phase-accumulator NCO: out = in · exp(−j·2π·acc/2^DDS_DW).
- Sits between the decimated 3.84 MSPS sample stream and the PSS/SSS detectors.
- New increments are staged and take effect only at a symbol boundary, so the rotation never jumps mid-symbol.

Parameters:
- IN_DW, 32: packed complex input width, {imag, real}, IN_DW/2 bits each, signed.
- OUT_DW, 32: packed complex output width, {imag, real}, signed.
- DDS_DW, 20: phase accumulator / increment width; 2^DDS_DW = 2π.
- LUT_DW, 10: quarter-wave sin ROM address bits.
- SIN_DW, 16: signed sin/cos amplitude width.
- RESET_PHASE_ON_SOF, 0: if 1, a SOF sample forces phase to 0.

Ports:
- clk_i, in, 1: clock.
- reset_i, in, 1: synchronous, active-high reset.
- s_axis_in_tdata, in, IN_DW: input sample {imag, real}.
- s_axis_in_tvalid, in, 1: input sample valid (no backpressure).
- sof_i, in, 1: qualifies the current valid sample as the first sample of a symbol.
- CFO_DDS_inc_i, in, DDS_DW: signed phase increment per sample.
- CFO_valid_i, in, 1: one-cycle strobe; latch CFO_DDS_inc_i as pending.
- m_axis_out_tdata, out, OUT_DW: derotated sample {imag, real}.
- m_axis_out_tvalid, out, 1: output valid.
- CFO_inc_active_o, out, DDS_DW: increment currently applied.
- pending_o, out, 1: a latched increment is waiting for the next SOF.

Behaviour:
- Reset (reset_i=1 at a clock edge):
  - acc, active increment, pending register, pending_o, CFO_inc_active_o, m_axis_out_tdata, all pipeline valids = 0.
  - Samples already in the pipeline are discarded.
  - Reset overrides every other input in the same cycle.
- Increment staging:
  - CFO_valid_i=1 writes pending_inc and sets pending_o=1.
  - A later strobe before SOF overwrites pending_inc.
- Apply:
  - Trigger is a valid input with sof_i=1 while a pending increment exists, including one arriving on CFO_valid_i in the same cycle (bypass: the same-cycle value wins).
  - Active increment := pending value; pending_o cleared the next cycle.
  - The new increment governs the accumulator update of that SOF sample.
  - sof_i without s_axis_in_tvalid is ignored.
- Accumulator, per valid sample:
  - phase_used = acc; acc <= acc + inc_active, modulo 2^DDS_DW (natural wrap, no saturation).
  - If RESET_PHASE_ON_SOF=1 and sof_i=1: phase_used = 0 and acc <= inc_active (new value if applied).
  - acc holds when there is no valid input.
- Phase to sin/cos:
  - Index = top LUT_DW+2 bits of (−phase_used) mod 2^DDS_DW; the 2 MSBs select the quadrant.
  - ROM[k] = round((2^(SIN_DW−1)−1)·sin(π/2·(k+0.5)/2^LUT_DW)).
  - cos/sin are derived by quadrant mirroring and negation.
- Complex multiply (θ = −2π·phase/2^DDS_DW):
  - re_o = re·cos − im·sin
  - im_o = re·sin + im·cos
  - Full-precision products, then add 2^(SIN_DW−2) and arithmetic right shift by SIN_DW−1 (round half up).
  - Saturate to ±(2^(OUT_DW/2−1)−1); the most negative code is never produced.
- Pipeline: fixed 4-cycle latency, valid in to valid out.
  - S1: phase capture and accumulator update.
  - S2: registered ROM read and quadrant mapping.
  - S3: registered products.
  - S4: sum, round, saturate.
  - Accepts one sample every cycle; m_axis_out_tvalid is s_axis_in_tvalid delayed by 4, gaps preserved.
- Output data holds its last value while m_axis_out_tvalid=0.

Test Plan:
- Identity: after reset inc=0; input (re=1000, im=0) ×8 → outputs (1000, 0) ±1, first valid exactly 4 cycles after first input.
- Quarter-turn rotation: CFO_valid_i with inc=2^18, then SOF + constant (8192, 0) → outputs (8192, 0), (0, −8192), (−8192, 0), (0, 8192), repeating, ±2 per component.
- Deferred apply: strobe inc=2^18 mid-symbol → pending_o=1, rotation unchanged until next SOF; from the SOF sample's accumulator update onward, steps are −90°; same-cycle strobe+SOF → new value used, pending_o never stays set.
- Wrap / negative inc: inc=2^20−1 (−1 LSB) for 2^20+5 samples → acc wraps with no discontinuity; inc=−2^18 gives +90° steps.
- Saturation: RESET_PHASE_ON_SOF=1, inc=2^17; SOF then (32767, 32767) ×2 → second output (32767, 0) (re clipped from ≈46340).
- Reset mid-stream: reset_i=1 for 1 cycle with 3 samples in flight → no m_axis_out_tvalid for those samples; CFO_inc_active_o=0, pending_o=0, next sample sees phase 0.

Source files
------------

// File: rtl/cfo_correction.sv
// Carrier-frequency-offset derotator: phase-accumulator NCO plus complex multiply.
// Increment updates are staged and only take effect on a symbol-start sample.
module cfo_correction #(
  parameter int IN_DW              = 32,
  parameter int OUT_DW             = 32,
  parameter int DDS_DW             = 20,
  parameter int LUT_DW             = 10,
  parameter int SIN_DW             = 16,
  parameter int RESET_PHASE_ON_SOF = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [IN_DW-1:0]  s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  input  logic              sof_i,
  input  logic [DDS_DW-1:0] CFO_DDS_inc_i,
  input  logic              CFO_valid_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  output logic [DDS_DW-1:0] CFO_inc_active_o,
  output logic              pending_o
);
  localparam int HW     = IN_DW / 2;
  localparam int OW     = OUT_DW / 2;
  localparam int PW     = HW + SIN_DW;
  localparam int NLUT   = 2 ** LUT_DW;
  localparam int STAGES = 4;
  localparam longint AMP = (longint'(1) <<< (SIN_DW - 1)) - 1;
  localparam logic signed [PW:0] RND  = (PW + 1)'(2 ** (SIN_DW - 2));
  localparam logic signed [PW:0] SMAX = (PW + 1)'(2 ** (OW - 1) - 1);
  localparam logic signed [PW:0] SMIN = -SMAX;

  // Quarter-wave ROM built at elaboration from a Q30 Taylor series of sin.
  function automatic logic [SIN_DW-2:0] rom_val(input int k);
    longint x, x2, term, sum, r;
    x    = (longint'(1686629713) * longint'(2 * k + 1)) >>> (LUT_DW + 1);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    r = (sum * AMP + (longint'(1) <<< 29)) >>> 30;
    return r[SIN_DW-2:0];
  endfunction

  function automatic logic [OW-1:0] sat(input logic signed [PW:0] v);
    if (v > SMAX) return SMAX[OW-1:0];
    if (v < SMIN) return SMIN[OW-1:0];
    return v[OW-1:0];
  endfunction

  logic [SIN_DW-2:0] rom [NLUT];
  for (genvar g = 0; g < NLUT; g++) begin : g_rom
    localparam logic [SIN_DW-2:0] V = rom_val(g);
    assign rom[g] = V;
  end

  // S1: increment staging and accumulator
  logic [DDS_DW-1:0] acc_q, acc_d, act_q, act_d, pinc_q, pinc_d, new_inc, phase_use, phase_q;
  logic              pend_q, pend_d, apply;
  logic signed [HW-1:0] re1_q, im1_q;
  logic [STAGES:1]   vld_pipe_q;

  always_comb begin
    apply     = s_axis_in_tvalid & sof_i & (pend_q | CFO_valid_i);
    new_inc   = CFO_valid_i ? CFO_DDS_inc_i : pinc_q;
    act_d     = apply ? new_inc : act_q;
    phase_use = (RESET_PHASE_ON_SOF != 0 && sof_i) ? '0 : acc_q;
    acc_d     = s_axis_in_tvalid ? phase_use + act_d : acc_q;
    pend_d    = apply ? 1'b0 : (CFO_valid_i | pend_q);
    pinc_d    = CFO_valid_i ? CFO_DDS_inc_i : pinc_q;
  end

  // S2: ROM lookup on the negated phase, quadrant folding
  logic [LUT_DW+1:0] idx;
  logic [LUT_DW-1:0] kk;
  logic signed [SIN_DW-1:0] ra, rb, sin_d, cos_d, sin_q, cos_q;
  logic signed [HW-1:0] re2_q, im2_q;

  always_comb begin
    idx   = (LUT_DW + 2)'((~phase_q + DDS_DW'(1)) >> (DDS_DW - LUT_DW - 2));
    kk    = idx[LUT_DW-1:0];
    ra    = {1'b0, rom[kk]};
    rb    = {1'b0, rom[~kk]};
    sin_d = ra;
    cos_d = rb;
    case (idx[LUT_DW+1:LUT_DW])
      2'd1:    begin sin_d = rb;  cos_d = -ra; end
      2'd2:    begin sin_d = -ra; cos_d = -rb; end
      2'd3:    begin sin_d = -rb; cos_d = ra;  end
      default: ;
    endcase
  end

  // S3 products, S4 round/saturate
  logic signed [PW-1:0] p_rc_q, p_is_q, p_rs_q, p_ic_q;
  logic signed [PW:0]   sum_re, sum_im;
  logic signed [OW-1:0] ore_q, oim_q;

  always_comb begin
    sum_re = ((PW + 1)'(p_rc_q) - (PW + 1)'(p_is_q) + RND) >>> (SIN_DW - 1);
    sum_im = ((PW + 1)'(p_rs_q) + (PW + 1)'(p_ic_q) + RND) >>> (SIN_DW - 1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0; act_q <= '0; pinc_q <= '0; pend_q <= 1'b0; phase_q <= '0;
      re1_q <= '0; im1_q <= '0; re2_q <= '0; im2_q <= '0; sin_q <= '0; cos_q <= '0;
      p_rc_q <= '0; p_is_q <= '0; p_rs_q <= '0; p_ic_q <= '0;
      ore_q <= '0; oim_q <= '0; vld_pipe_q <= '0;
    end else begin
      acc_q      <= acc_d;
      act_q      <= act_d;
      pinc_q     <= pinc_d;
      pend_q     <= pend_d;
      phase_q    <= phase_use;
      re1_q      <= s_axis_in_tdata[HW-1:0];
      im1_q      <= s_axis_in_tdata[IN_DW-1:HW];
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], s_axis_in_tvalid};
      re2_q      <= re1_q;
      im2_q      <= im1_q;
      sin_q      <= sin_d;
      cos_q      <= cos_d;
      p_rc_q     <= PW'(re2_q) * PW'(cos_q);
      p_is_q     <= PW'(im2_q) * PW'(sin_q);
      p_rs_q     <= PW'(re2_q) * PW'(sin_q);
      p_ic_q     <= PW'(im2_q) * PW'(cos_q);
      if (vld_pipe_q[STAGES-1]) begin
        ore_q <= sat(sum_re);
        oim_q <= sat(sum_im);
      end
    end
  end

  assign m_axis_out_tdata  = {oim_q, ore_q};
  assign m_axis_out_tvalid = vld_pipe_q[STAGES];
  assign CFO_inc_active_o  = act_q;
  assign pending_o         = pend_q;
endmodule

// File: tb/tb_cfo_correction.sv
// Directed vector bench for cfo_correction; two instances differ only in RESET_PHASE_ON_SOF.
module tb_cfo_correction;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic        tvalid, sof, cfo_v;
  logic [19:0] cfo_inc;
  logic [31:0] out_a, out_b;
  logic        vld_a, vld_b, pend_a, pend_b;
  logic [19:0] act_a, act_b;
  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  cfo_correction u_a (
    .clk_i(clk), .reset_i(rst), .s_axis_in_tdata(tdata), .s_axis_in_tvalid(tvalid),
    .sof_i(sof), .CFO_DDS_inc_i(cfo_inc), .CFO_valid_i(cfo_v),
    .m_axis_out_tdata(out_a), .m_axis_out_tvalid(vld_a),
    .CFO_inc_active_o(act_a), .pending_o(pend_a));

  cfo_correction #(.RESET_PHASE_ON_SOF(1)) u_b (
    .clk_i(clk), .reset_i(rst), .s_axis_in_tdata(tdata), .s_axis_in_tvalid(tvalid),
    .sof_i(sof), .CFO_DDS_inc_i(cfo_inc), .CFO_valid_i(cfo_v),
    .m_axis_out_tdata(out_b), .m_axis_out_tvalid(vld_b),
    .CFO_inc_active_o(act_b), .pending_o(pend_b));

  typedef struct {
    logic vld, sof, cv;
    logic [19:0] inc;
    int re, im, ere, eim;
    logic epend;
    logic [19:0] eact;
  } vec_t;
  vec_t tv[$];

  // Expected outputs for input (8192,0) at phase 0, 1/4, 1/2, 3/4 turn
  int qre[4] = '{8192, 6, -8192, -6};
  int qim[4] = '{6, -8192, -6, 8192};

  task automatic chk(input string nm, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic drive(input logic v, s, cv, input logic [19:0] inc, input int re, im);
    tvalid = v; sof = s; cfo_v = cv; cfo_inc = inc;
    tdata = {16'(im), 16'(re)};
  endtask

  task automatic add(input logic v, s, cv, input logic [19:0] inc, input int re, im, ere, eim,
                     input logic epend, input logic [19:0] eact);
    vec_t t;
    t.vld = v; t.sof = s; t.cv = cv; t.inc = inc; t.re = re; t.im = im;
    t.ere = ere; t.eim = eim; t.epend = epend; t.eact = eact;
    tv.push_back(t);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_table(input string nm, input bit use_b);
    int n, j;
    logic ev, ov;
    logic [31:0] od;
    n = tv.size();
    for (int c = 0; c < n + 4; c++) begin
      if (c < n) drive(tv[c].vld, tv[c].sof, tv[c].cv, tv[c].inc, tv[c].re, tv[c].im);
      else       drive(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      if (c < n) begin
        chk($sformatf("%s[%0d] pending", nm, c), int'(use_b ? pend_b : pend_a), int'(tv[c].epend));
        chk($sformatf("%s[%0d] active", nm, c), int'(use_b ? act_b : act_a), int'(tv[c].eact));
      end
      j  = c - 3;
      ev = (j >= 0 && j < n) ? tv[j].vld : 1'b0;
      ov = use_b ? vld_b : vld_a;
      od = use_b ? out_b : out_a;
      chk($sformatf("%s out%0d valid", nm, j), int'(ov), int'(ev));
      if (ev && ov) begin
        chk($sformatf("%s out%0d re", nm, j), int'($signed(od[15:0])), tv[j].ere);
        chk($sformatf("%s out%0d im", nm, j), int'($signed(od[31:16])), tv[j].eim);
      end
    end
    tv.delete();
  endtask

  initial begin
    bit seen;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    do_reset();
    chk("reset valid", int'(vld_a | vld_b), 0);
    chk("reset tdata", int'(out_a | out_b), 0);
    chk("reset active", int'(act_a | act_b), 0);
    chk("reset pending", int'(pend_a | pend_b), 0);

    // identity with a gap at index 3
    for (int i = 0; i < 9; i++) add(i != 3, 0, 0, 0, 1000, 0, 1000, 1, 0, 0);
    run_table("ident", 0);

    do_reset();
    add(0, 0, 1, 20'h40000, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      add(1, i == 0, 0, 0, 8192, 0, qre[i % 4], qim[i % 4], 0, 20'h40000);
    run_table("quarter", 0);

    // deferred apply, overwrite, sof without valid, same-cycle strobe+sof with -1/4 turn
    do_reset();
    add(1, 1, 0, 0,          8192, 0, qre[0], qim[0], 0, 0);
    add(1, 0, 1, 20'h20000,  8192, 0, qre[0], qim[0], 1, 0);
    add(1, 0, 1, 20'h40000,  8192, 0, qre[0], qim[0], 1, 0);
    add(0, 1, 0, 0,          0,    0, 0,      0,      1, 0);
    add(1, 1, 0, 0,          8192, 0, qre[0], qim[0], 0, 20'h40000);
    add(1, 0, 0, 0,          8192, 0, qre[1], qim[1], 0, 20'h40000);
    add(1, 0, 0, 0,          8192, 0, qre[2], qim[2], 0, 20'h40000);
    add(1, 1, 1, 20'hC0000,  8192, 0, qre[3], qim[3], 0, 20'hC0000);
    add(1, 0, 0, 0,          8192, 0, qre[2], qim[2], 0, 20'hC0000);
    add(1, 0, 0, 0,          8192, 0, qre[1], qim[1], 0, 20'hC0000);
    add(1, 0, 0, 0,          8192, 0, qre[0], qim[0], 0, 20'hC0000);
    add(1, 0, 0, 0,          8192, 0, qre[3], qim[3], 0, 20'hC0000);
    run_table("defer", 0);

    // -1 LSB increment wraps below zero without visible phase change
    do_reset();
    for (int i = 0; i < 6; i++)
      add(1, i == 0, i == 0, 20'hFFFFF, 8192, 0, qre[0], qim[0], 0, 20'hFFFFF);
    run_table("wrap", 0);

    // saturation on the phase-resetting instance
    do_reset();
    add(0, 0, 1, 20'h20000, 0,      0,      0,      0,      1, 0);
    add(1, 1, 0, 0,         32767,  32767,  32741,  32767,  0, 20'h20000);
    add(1, 0, 0, 0,         32767,  32767,  32767,  36,     0, 20'h20000);
    add(1, 1, 0, 0,         -32768, -32768, -32742, -32767, 0, 20'h20000);
    add(1, 0, 0, 0,         -32768, -32768, -32767, -36,    0, 20'h20000);
    run_table("sat", 1);

    // reset with three samples in flight
    drive(0, 0, 1, 20'h12345, 0, 0);
    @(posedge clk); #1;
    chk("midrst pending set", int'(pend_a), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 8192, 0);
      @(posedge clk); #1;
    end
    drive(1, 1, 1, 20'h40000, 8192, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("midrst active", int'(act_a), 0);
    chk("midrst pending", int'(pend_a), 0);
    chk("midrst tdata", int'(out_a), 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("midrst flushed %0d", i), int'(vld_a), 0);
      @(posedge clk); #1;
    end
    drive(1, 0, 0, 0, 8192, 0);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0);
      if (vld_a) begin
        seen = 1'b1;
        chk("midrst latency", k, 3);
        chk("midrst re", int'($signed(out_a[15:0])), qre[0]);
        chk("midrst im", int'($signed(out_a[31:16])), qim[0]);
      end
    end
    if (!seen) chk("midrst output timeout", 0, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
